i2c_wb_arbiter: RTL
===================

Name: i2c_wb_arbiter

Overview:
- Shares the single Wishbone slave port of the I2C master core (prescale/control/TX/RX/command/status registers, 3-bit address, 8-bit data) between NUM_REQ Wishbone masters, e.g. the TCA9555 poller and a board-EEPROM reader.
- A requester can hold a lock so that every register access of one I2C transaction (ID, start, addr, data, stop, status polls) stays atomic.
- Round-robin arbitration; an ack watchdog frees the bus if the slave hangs.
- Sits between the per-function Wishbone controllers and the I2C master core.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ACK_TIMEOUT, 64, cycles in ACTIVE without slave ack before abort (>=4).

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  reset; synchronous, active-low.
- i_req_cyc  in  NUM_REQ  per-requester CYC.
- i_req_stb  in  NUM_REQ  per-requester STB.
- i_req_we  in  NUM_REQ  per-requester WE.
- i_req_adr  in  3*NUM_REQ  packed addresses; requester k uses bits [3k+2:3k].
- i_req_dat  in  8*NUM_REQ  packed write data; requester k uses bits [8k+7:8k].
- i_req_lock  in  NUM_REQ  keep ownership after the current ack.
- o_req_dat  out  8  read data, shared; valid only with that requester's ack.
- o_req_ack  out  NUM_REQ  per-requester ACK.
- o_req_err  out  NUM_REQ  one-cycle abort pulse to the owner on timeout.
- o_grant  out  NUM_REQ  one-hot current owner; 0 when the bus is free.
- o_wbs_cyc, o_wbs_stb, o_wbs_we  out  1 each  to the slave.
- o_wbs_adr  out  3  to the slave.
- o_wbs_dat  out  8  to the slave.
- i_wbs_dat  in  8  from the slave.
- i_wbs_ack  in  1  from the slave.

Behaviour:
- Reset (i_reset_n=0 at a clock edge):
  - state=IDLE; o_grant=0; o_req_ack=0; o_req_err=0; all o_wbs_* = 0; timeout counter=0.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
  - Reset mid-transfer drops o_wbs_cyc/stb at that edge; a pending ack is not forwarded.
- A requester is pending when i_req_cyc[k] & i_req_stb[k].
- States:
  - IDLE: if any requester is pending, pick the first pending one searching from (last_grant+1) mod NUM_REQ upward with wrap. Register owner and o_grant, then go to ACTIVE. Grant latency is 1 cycle: request seen at edge N, o_wbs_stb=1 from cycle N+1.
  - ACTIVE:
    - o_wbs_cyc=1, o_wbs_stb=1.
    - o_wbs_we/adr/dat are a combinational mux of the owner's inputs; requesters hold them stable until ack.
    - o_req_ack[owner]=i_wbs_ack, combinational, same cycle; o_req_dat=i_wbs_dat.
    - On ack: last_grant=owner, timeout counter cleared. Go to HOLD if i_req_lock[owner] is sampled 1 in the ack cycle, else RELEASE.
    - If the counter reaches ACK_TIMEOUT-1 with no ack: pulse o_req_err[owner] for 1 cycle, drop cyc/stb, go to RELEASE regardless of lock.
  - HOLD:
    - o_grant is held and o_wbs_cyc=o_wbs_stb=0.
    - Owner pending → ACTIVE next cycle.
    - Otherwise, i_req_lock[owner]=0 → RELEASE.
    - Other requesters stall, with no timeout on HOLD; I2C status polling may hold for long periods.
  - RELEASE: one turnaround cycle. o_grant=0, no arbitration, then go to IDLE. This guarantees the previous owner has dropped STB before the next arbitration.
- Non-owners always see o_req_ack=0; an ack from the slave while not in ACTIVE is ignored.
- Width rules:
  - Owner index is clog2(NUM_REQ) bits.
  - Timeout counter is clog2(ACK_TIMEOUT) bits, saturating and cleared on each entry to ACTIVE.
- Simultaneous lock drop and stb in HOLD: stb wins, go to ACTIVE.
- Owner drops cyc while in ACTIVE (protocol violation): treated like a missing ack, i.e. the watchdog path applies.

Test Plan:
- Single access: req0 pending, write adr=3'b011 dat=8'h40, lock=0; slave acks 2 cycles after stb.
  - Required: o_grant=01 one cycle after request; o_wbs_adr=3, o_wbs_dat=8'h40 while stb is high.
  - Required: o_req_ack[0] in the slave-ack cycle, then RELEASE, then IDLE.
- Round-robin: req0 and req1 pending continuously with lock=0 → grants alternate 0,1,0,1 over 4 accesses; neither requester gets two consecutive grants.
- Lock: req0 locks across 5 accesses (TXR, CR, then 3 SR polls) while req1 is pending throughout.
  - Required: req1 is not acked until req0 drops lock.
  - Required: req1 is granted exactly 2 cycles after the HOLD→RELEASE transition.
- Read path: req1 reads adr=3'b100 and the slave returns 8'h02 with ack → o_req_dat=8'h02 and o_req_ack=10 in the same cycle.
- Timeout: slave never acks req0 with ACK_TIMEOUT=64.
  - Required: o_req_err[0] pulses at the 64th ACTIVE cycle; cyc/stb drop and the bus is released even with lock=1.
  - Required: req1 is then served.
- Reset mid-operation: i_reset_n=0 during ACTIVE for req1 → next cycle all outputs are 0; after release, a simultaneous req0/req1 request is granted to req0.

Source files
------------

// File: rtl/i2c_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing the I2C master core's register port
// among NUM_REQ requesters, with per-transaction lock and an ack watchdog.
module i2c_wb_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [NUM_REQ-1:0]   i_req_cyc,
  input  logic [NUM_REQ-1:0]   i_req_stb,
  input  logic [NUM_REQ-1:0]   i_req_we,
  input  logic [3*NUM_REQ-1:0] i_req_adr,
  input  logic [8*NUM_REQ-1:0] i_req_dat,
  input  logic [NUM_REQ-1:0]   i_req_lock,
  output logic [7:0]           o_req_dat,
  output logic [NUM_REQ-1:0]   o_req_ack,
  output logic [NUM_REQ-1:0]   o_req_err,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_wbs_cyc,
  output logic                 o_wbs_stb,
  output logic                 o_wbs_we,
  output logic [2:0]           o_wbs_adr,
  output logic [7:0]           o_wbs_dat,
  input  logic [7:0]           i_wbs_dat,
  input  logic                 i_wbs_ack
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD, RELEASE} state_t;

  state_t             state_q;
  logic [OW-1:0]      owner_q, last_q;
  logic [CW-1:0]      cnt_q;
  logic [NUM_REQ-1:0] grant_q;

  logic [NUM_REQ-1:0] pend;
  logic               pick_vld_d;
  logic [OW-1:0]      pick_d;
  logic               active, timeout;

  assign pend    = i_req_cyc & i_req_stb;
  assign active  = (state_q == ACTIVE);
  assign timeout = active && !i_wbs_ack && (cnt_q == CNT_LAST);

  // First pending requester after the last one acked, wrapping around.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_d     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(last_q) + i) % NUM_REQ;
      if (!pick_vld_d && pend[idx]) begin
        pick_vld_d = 1'b1;
        pick_d     = OW'(idx);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OW'(NUM_REQ - 1);
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (pick_vld_d) begin
          state_q <= ACTIVE;
          owner_q <= pick_d;
          grant_q <= NUM_REQ'(1) << pick_d;
          cnt_q   <= '0;
        end
        ACTIVE: begin
          if (i_wbs_ack) begin
            last_q  <= owner_q;
            cnt_q   <= '0;
            state_q <= i_req_lock[owner_q] ? HOLD : RELEASE;
          end else if (timeout) begin
            state_q <= RELEASE;
          end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end
          if (!i_wbs_ack && timeout) grant_q <= '0;
          else if (i_wbs_ack && !i_req_lock[owner_q]) grant_q <= '0;
        end
        // Lock holds the port with no watchdog: status polling may idle here.
        HOLD: begin
          if (pend[owner_q]) begin
            state_q <= ACTIVE;
            cnt_q   <= '0;
          end else if (!i_req_lock[owner_q]) begin
            state_q <= RELEASE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    o_req_ack = '0;
    o_req_err = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      o_req_ack[k] = active && i_wbs_ack && (owner_q == OW'(k));
      o_req_err[k] = timeout && (owner_q == OW'(k));
    end
  end

  assign o_grant   = grant_q;
  assign o_req_dat = i_wbs_dat;
  assign o_wbs_cyc = active;
  assign o_wbs_stb = active;
  assign o_wbs_we  = active && i_req_we[owner_q];
  assign o_wbs_adr = active ? i_req_adr[3*owner_q +: 3] : 3'd0;
  assign o_wbs_dat = active ? i_req_dat[8*owner_q +: 8] : 8'd0;
endmodule
